mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared pipeline defines for the memory port arbiter
package mem_port_arbiter_pkg;

  // Arbiter FSM encodings
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_IF  = 2'd1,
    GRANT_MEM = 2'd2
  } arb_state_e;

  // Consecutive MEM grants allowed while a fetch is waiting
  localparam int STARVE_LIMIT_DEFAULT = 4;

  // Width of the starvation counter
  localparam int STARVE_CNT_W = 3;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between the fetch and load/store stages
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_valid,
  output logic          IF_stall,
  output logic          MEM_stall,
  output logic          ram_req,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  input  logic          ram_ack
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = 3'(STARVE_LIMIT);

  arb_state_e              state_q;
  logic [STARVE_CNT_W-1:0] starve_cnt_q;
  logic [STARVE_CNT_W-1:0] starve_cnt_d;
  logic                    discard_q;
  logic                    ram_req_q;
  logic                    ram_we_q;
  logic [AW-1:0]           ram_addr_q;
  logic [DW-1:0]           ram_wdata_q;
  logic                    if_valid_q;
  logic                    mem_valid_q;
  logic [DW-1:0]           if_rdata_q;
  logic [DW-1:0]           mem_rdata_q;

  logic mem_want;
  logic turnaround;
  logic if_starved;
  logic grant_mem;
  logic grant_if;

  // A completion cycle is a turnaround: the finishing requester has not yet
  // dropped or replaced its request, so no grant is issued while a valid is high.
  assign mem_want   = mem_rd | mem_wr;
  assign turnaround = if_valid_q | mem_valid_q;
  assign if_starved = if_req & (starve_cnt_q == STARVE_MAX);
  assign grant_mem  = (state_q == IDLE) & ~turnaround & mem_want & ~if_starved;
  assign grant_if   = (state_q == IDLE) & ~turnaround & if_req & ~grant_mem;

  // Starvation counter: counts MEM grants taken while a fetch waits, saturating
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req || grant_if) begin
      starve_cnt_d = '0;
    end else if (grant_mem && (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end
  end

  // Arbiter FSM with registered memory-side outputs and completion pulses
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      discard_q    <= 1'b0;
      ram_req_q    <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      if_valid_q   <= 1'b0;
      mem_valid_q  <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
    end else begin
      if_valid_q   <= 1'b0;
      mem_valid_q  <= 1'b0;
      starve_cnt_q <= starve_cnt_d;
      case (state_q)
        IDLE: begin
          if (grant_mem) begin
            state_q     <= GRANT_MEM;
            ram_req_q   <= 1'b1;
            ram_we_q    <= mem_wr;
            ram_addr_q  <= mem_addr;
            ram_wdata_q <= mem_wdata;
          end else if (grant_if) begin
            state_q    <= GRANT_IF;
            ram_req_q  <= 1'b1;
            ram_we_q   <= 1'b0;
            ram_addr_q <= if_addr;
          end
        end
        GRANT_IF: begin
          if (ram_ack) begin
            state_q   <= IDLE;
            ram_req_q <= 1'b0;
            discard_q <= 1'b0;
            // A redirect seen at any point of the fetch, ack cycle included, drops its data
            if (!discard_q && !if_flush) begin
              if_rdata_q <= ram_rdata;
              if_valid_q <= 1'b1;
            end
          end else if (if_flush) begin
            discard_q <= 1'b1;
          end
        end
        GRANT_MEM: begin
          if (ram_ack) begin
            state_q     <= IDLE;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            mem_valid_q <= 1'b1;
            if (!ram_we_q) begin
              mem_rdata_q <= ram_rdata;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          ram_req_q <= 1'b0;
          ram_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_rdata = mem_rdata_q;

  assign IF_stall  = if_req & ~if_valid_q;
  assign MEM_stall = mem_want & ~mem_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        if_req, if_flush, mem_rd, mem_wr, ram_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic        if_valid, mem_valid, IF_stall, MEM_stall, ram_req, ram_we;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIMIT)) dut (
    .Clk(Clk), .Rst(Rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .IF_stall(IF_stall), .MEM_stall(MEM_stall),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          if_r;
    bit          mrd;
    bit          mwr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_dly;
    logic [31:0] rdata;
    bit          exp_we;
    bit          exp_ifv;
    bit          exp_memv;
    logic [31:0] exp_ifd;
    logic [31:0] exp_memd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_grant(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (ram_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL grant_timeout: got no ram_req within %0d cycles expected a grant", limit);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    if_req = v.if_r; if_addr = v.addr;
    mem_rd = v.mrd; mem_wr = v.mwr; mem_addr = v.addr; mem_wdata = v.wdata;
    #1;
    chk($sformatf("v%0d_if_stall_req", idx), IF_stall, v.if_r);
    chk($sformatf("v%0d_mem_stall_req", idx), MEM_stall, v.mrd | v.mwr);
    step();
    chk($sformatf("v%0d_ram_req", idx), ram_req, 1);
    chk($sformatf("v%0d_ram_addr", idx), ram_addr, v.addr);
    chk($sformatf("v%0d_ram_we", idx), ram_we, v.exp_we);
    if (v.exp_we) chk($sformatf("v%0d_ram_wdata", idx), ram_wdata, v.wdata);
    for (int i = 0; i < v.ack_dly; i++) begin
      step();
      chk($sformatf("v%0d_ram_req_hold", idx), ram_req, 1);
      chk($sformatf("v%0d_ram_addr_hold", idx), ram_addr, v.addr);
    end
    ram_ack = 1'b1; ram_rdata = v.rdata;
    step();
    ram_ack = 1'b0; ram_rdata = 32'h0BAD0BAD;
    chk($sformatf("v%0d_if_valid", idx), if_valid, v.exp_ifv);
    chk($sformatf("v%0d_mem_valid", idx), mem_valid, v.exp_memv);
    chk($sformatf("v%0d_if_rdata", idx), if_rdata, v.exp_ifd);
    chk($sformatf("v%0d_mem_rdata", idx), mem_rdata, v.exp_memd);
    chk($sformatf("v%0d_ram_req_done", idx), ram_req, 0);
    chk($sformatf("v%0d_if_stall_done", idx), IF_stall, v.if_r & ~v.exp_ifv);
    chk($sformatf("v%0d_mem_stall_done", idx), MEM_stall, (v.mrd | v.mwr) & ~v.exp_memv);
    if_req = 0; mem_rd = 0; mem_wr = 0;
    step();
    chk($sformatf("v%0d_pulse_end", idx), {if_valid, mem_valid}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    int   exp_seq[6];
    int   mem_done;
    bit   act, a_if, a_we, disc, pv_if, pv_mem, e_ifv, e_memv;
    logic [31:0] a_addr, a_wdata, e_ifd, e_memd;
    int   consec, sel;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h40,  32'h0,        2, 32'h8C010004, 1'b0, 1'b1, 1'b0, 32'h8C010004, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h100, 32'h0,        0, 32'hCAFE0001, 1'b0, 1'b0, 1'b1, 32'h8C010004, 32'hCAFE0001};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h200, 32'h12345678, 1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'h8C010004, 32'hCAFE0001};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h204, 32'hA5A5A5A5, 3, 32'h11111111, 1'b1, 1'b0, 1'b1, 32'h8C010004, 32'hCAFE0001};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h44,  32'h0,        0, 32'h00000013, 1'b0, 1'b1, 1'b0, 32'h00000013, 32'hCAFE0001};
    exp_seq = '{1, 1, 1, 1, 0, 1};

    Rst = 1; if_req = 0; if_flush = 0; if_addr = 0; mem_rd = 0; mem_wr = 0;
    mem_addr = 0; mem_wdata = 0; ram_ack = 0; ram_rdata = 0;
    step(); step();
    Rst = 0;
    chk("rst_ram_req", ram_req, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_valids", {if_valid, mem_valid}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_stalls", {IF_stall, MEM_stall}, 0);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Fetch redirected while granted: data dropped, if_rdata keeps 0x13
    if_req = 1; if_addr = 32'h60;
    step();
    chk("flush_grant_addr", ram_addr, 32'h60);
    if_flush = 1; if_addr = 32'h80;
    step();
    if_flush = 0; ram_ack = 1; ram_rdata = 32'hDEADBEEF;
    step();
    ram_ack = 0;
    chk("flush_no_valid", if_valid, 0);
    chk("flush_rdata_kept", if_rdata, 32'h13);
    chk("flush_ram_req_low", ram_req, 0);
    if_req = 0;
    step();
    chk("flush_no_late_valid", if_valid, 0);

    // Redirect arriving in the ack cycle itself
    if_req = 1; if_addr = 32'h90;
    step();
    ram_ack = 1; if_flush = 1; ram_rdata = 32'h5555AAAA;
    step();
    ram_ack = 0; if_flush = 0;
    chk("ackflush_no_valid", if_valid, 0);
    chk("ackflush_rdata_kept", if_rdata, 32'h13);
    if_req = 0;
    step();

    // Clean fetch afterwards: discard must not linger
    if_req = 1; if_addr = 32'hA0;
    step();
    ram_ack = 1; ram_rdata = 32'h600D0001;
    step();
    ram_ack = 0;
    chk("postflush_valid", if_valid, 1);
    chk("postflush_rdata", if_rdata, 32'h600D0001);
    if_req = 0;
    step();

    // Flush during a MEM access is ignored
    mem_rd = 1; mem_addr = 32'h300;
    step();
    if_flush = 1; ram_ack = 1; ram_rdata = 32'h77;
    step();
    if_flush = 0; ram_ack = 0;
    chk("memflush_valid", mem_valid, 1);
    chk("memflush_rdata", mem_rdata, 32'h77);
    mem_rd = 0;
    step();

    // Simultaneous requests: MEM wins, IF follows
    if_req = 1; if_addr = 32'h80; mem_rd = 1; mem_addr = 32'h100;
    step();
    chk("both_first_addr", ram_addr, 32'h100);
    chk("both_first_we", ram_we, 0);
    ram_ack = 1; ram_rdata = 32'h01020304;
    step();
    ram_ack = 0;
    chk("both_mem_valid", mem_valid, 1);
    chk("both_mem_rdata", mem_rdata, 32'h01020304);
    chk("both_if_idle", if_valid, 0);
    mem_rd = 0;
    wait_grant(4);
    chk("both_second_addr", ram_addr, 32'h80);
    ram_ack = 1; ram_rdata = 32'h00000080;
    step();
    ram_ack = 0;
    chk("both_if_valid", if_valid, 1);
    if_req = 0;
    step();

    // Starvation: fetch held through five back-to-back stores
    if_req = 1; if_addr = 32'h500; mem_wr = 1; mem_addr = 32'h340; mem_wdata = 32'h0000ABCD;
    mem_done = 0;
    for (int g = 0; g < 6; g++) begin
      wait_grant(8);
      chk($sformatf("starve_grant%0d_is_mem", g), ram_we, exp_seq[g]);
      ram_ack = 1;
      step();
      ram_ack = 0;
      if (mem_valid) begin
        mem_done++;
        mem_addr = mem_addr + 4;
        if (mem_done == 5) mem_wr = 0;
      end
      if (if_valid) if_addr = if_addr + 4;
    end
    if_req = 0; mem_wr = 0;
    step(); step();

    // Reset in the middle of a MEM access, then a stale ack
    mem_rd = 1; mem_addr = 32'h700;
    step();
    chk("rstmid_granted", ram_req, 1);
    Rst = 1; mem_rd = 0;
    step();
    Rst = 0; ram_ack = 1; ram_rdata = 32'hBADBAD00;
    chk("rstmid_ram_req", ram_req, 0);
    chk("rstmid_ram_addr", ram_addr, 0);
    chk("rstmid_no_valid", mem_valid, 0);
    step();
    ram_ack = 0;
    chk("rstmid_stale_ack_valid", mem_valid, 0);
    chk("rstmid_stale_ack_req", ram_req, 0);
    chk("rstmid_mem_rdata", mem_rdata, 0);
    if_req = 1; if_addr = 32'h44;
    step();
    chk("rstmid_idle_grant", ram_req, 1);
    chk("rstmid_idle_addr", ram_addr, 32'h44);
    ram_ack = 1; ram_rdata = 32'h0000CAFE;
    step();
    ram_ack = 0;
    chk("rstmid_fetch_valid", if_valid, 1);
    if_req = 0;
    step();

    // Randomized traffic against a transaction-level reference
    Rst = 1; if_req = 0; mem_rd = 0; mem_wr = 0; if_flush = 0; ram_ack = 0;
    step();
    Rst = 0;
    act = 0; a_if = 0; a_we = 0; disc = 0; a_addr = 0; a_wdata = 0;
    e_ifv = 0; e_memv = 0; e_ifd = 0; e_memd = 0; consec = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      step();
      pv_if = e_ifv; pv_mem = e_memv;
      e_ifv = 0; e_memv = 0;
      if (act) begin
        if (ram_ack) begin
          act = 0;
          if (a_if) begin
            if (!(disc || if_flush)) begin
              e_ifv = 1; e_ifd = ram_rdata;
            end
          end else begin
            e_memv = 1;
            if (!a_we) e_memd = ram_rdata;
          end
          disc = 0;
        end else if (a_if && if_flush) begin
          disc = 1;
        end
      end else if (!(pv_if || pv_mem)) begin
        if ((mem_rd || mem_wr) && !(consec == LIMIT && if_req)) begin
          act = 1; a_if = 0; a_we = mem_wr; a_addr = mem_addr; a_wdata = mem_wdata;
          if (if_req && consec < LIMIT) consec++;
        end else if (if_req) begin
          act = 1; a_if = 1; a_we = 0; a_addr = if_addr; disc = 0;
          consec = 0;
        end
      end
      if (!if_req) consec = 0;

      chk("rnd_ram_req", ram_req, act);
      if (act) begin
        chk("rnd_ram_addr", ram_addr, a_addr);
        chk("rnd_ram_we", ram_we, a_we);
        if (a_we) chk("rnd_ram_wdata", ram_wdata, a_wdata);
      end
      chk("rnd_if_valid", if_valid, e_ifv);
      chk("rnd_mem_valid", mem_valid, e_memv);
      chk("rnd_if_rdata", if_rdata, e_ifd);
      chk("rnd_mem_rdata", mem_rdata, e_memd);

      if_flush = 0;
      if (act && a_if && $urandom_range(0, 5) == 0) begin
        if_flush = 1;
        if_addr = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC);
      end else if (!(act && a_if) && $urandom_range(0, 9) == 0) begin
        if_flush = 1;
      end
      if (if_req) begin
        if (e_ifv) begin
          if ($urandom_range(0, 1) == 0) if_req = 0;
          else if_addr = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC);
        end
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1;
        if_addr = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC);
      end
      if (mem_rd || mem_wr) begin
        if (e_memv) begin
          if ($urandom_range(0, 1) == 0) begin
            mem_rd = 0; mem_wr = 0;
          end else begin
            sel = $urandom_range(0, 2);
            mem_rd = (sel != 1); mem_wr = (sel != 0);
            mem_addr = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFC);
            mem_wdata = $urandom;
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        sel = $urandom_range(0, 2);
        mem_rd = (sel != 1); mem_wr = (sel != 0);
        mem_addr = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFC);
        mem_wdata = $urandom;
      end
      ram_ack = act ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
      ram_rdata = $urandom;
      #1;
      chk("rnd_if_stall", IF_stall, if_req & ~e_ifv);
      chk("rnd_mem_stall", MEM_stall, (mem_rd | mem_wr) & ~e_memv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
